// File: rtl/serial_sub_pkg.sv
// Shared types and bit-level helpers for the bit-serial subtractor.
// The two helper functions are the single source of the per-bit
// difference/borrow equations used by the full-subtract cell.
package serial_sub_pkg;

    // Controller states; encodings are fixed so they read the same in every tool.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Difference bit of a - b - bin.
    function automatic logic bit_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow out of a - b - bin: borrow when b exceeds a, or when a == b
    // and a borrow is already pending.
    function automatic logic bit_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: d = a - b - bin, bout = borrow out.
// Purely combinational; the caller registers the borrow between bits.
module full_sub_cell
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = bit_diff(a, b, bin);
    assign bout = bit_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, Diff = A - B, LSB first, one bit per clock.
// start is taken only in IDLE; RUN lasts N cycles; DONE is a one-cycle
// pulse in which Diff/Borrow are already valid. Diff/Borrow are only ever
// loaded with a complete result, so they never show partial values.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         Borrow
);

    // One extra bit keeps the width non-zero for N == 1.
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t state_reg, state_next;

    logic [N-1:0]     sh_a_reg, sh_a_next;
    logic [N-1:0]     sh_b_reg, sh_b_next;
    logic [N-1:0]     res_reg, res_next;
    logic [N-1:0]     res_shifted;
    logic             borrow_reg, borrow_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N-1:0]     diff_reg, diff_next;
    logic             borrow_out_reg, borrow_out_next;

    logic cell_d;
    logic cell_bout;

    // The only arithmetic in the datapath: current LSB pair plus the held borrow.
    full_sub_cell u_cell (
        .a    (sh_a_reg[0]),
        .b    (sh_b_reg[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result register after this cycle's bit lands at the MSB; after N
    // shifts the first (LSB) difference bit has walked down to bit 0.
    always_comb begin
        res_shifted        = res_reg >> 1;
        res_shifted[N-1]   = cell_d;
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and datapath next values; everything holds by default.
    always_comb begin
        state_next      = state_reg;
        sh_a_next       = sh_a_reg;
        sh_b_next       = sh_b_reg;
        res_next        = res_reg;
        borrow_next     = borrow_reg;
        cnt_next        = cnt_reg;
        diff_next       = diff_reg;
        borrow_out_next = borrow_out_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sh_a_next   = A;
                    sh_b_next   = B;
                    res_next    = '0;
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end

            RUN: begin
                sh_a_next   = sh_a_reg >> 1;
                sh_b_next   = sh_b_reg >> 1;
                res_next    = res_shifted;
                borrow_next = cell_bout;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    // Publish the whole word and the MSB borrow together.
                    diff_next       = res_shifted;
                    borrow_out_next = cell_bout;
                    state_next      = DONE;
                end
            end

            DONE: begin
                // start is deliberately ignored here; the next request is
                // taken from IDLE only.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: operand shifters, borrow flop, counter, results.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a_reg       <= '0;
            sh_b_reg       <= '0;
            res_reg        <= '0;
            borrow_reg     <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
        end else begin
            sh_a_reg       <= sh_a_next;
            sh_b_reg       <= sh_b_next;
            res_reg        <= res_next;
            borrow_reg     <= borrow_next;
            cnt_reg        <= cnt_next;
            diff_reg       <= diff_next;
            borrow_out_reg <= borrow_out_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign Diff   = diff_reg;
    assign Borrow = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an N=8 and an N=1 instance side by side.
// Expected results (value, borrow, done cycle) are queued when a request is
// issued and checked when the DUT pulses done.
module tb_serial_subtractor;

    localparam int N8 = 8;
    localparam int N1 = 1;

    typedef struct {
        logic [7:0] diff;
        logic       borrow;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start1, busy1, done1, borrow1;
    logic [0:0] a1, b1, diff1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ops    = 0;

    exp_t q8[$];
    exp_t q1[$];

    serial_subtractor #(.N(N8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Diff(diff8), .Borrow(borrow8)
    );

    serial_subtractor #(.N(N1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumers: one per instance, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 1, 0);
            end else begin
                e = q8.pop_front();
                ops++;
                $display("op%0d N=8: Diff=%02h Borrow=%b at cycle %0d", ops, diff8, borrow8, cyc);
                check("diff8", diff8, e.diff);
                check("borrow8", borrow8, e.borrow);
                check("done_cycle8", cyc, e.cyc);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                ops++;
                $display("op%0d N=1: Diff=%0d Borrow=%b at cycle %0d", ops, diff1, borrow1, cyc);
                check("diff1", diff1, e.diff);
                check("borrow1", borrow1, e.borrow);
                check("done_cycle1", cyc, e.cyc);
            end
        end
    end

    // Called on a falling edge with the N=8 DUT idle; returns one cycle later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        a8 = a; b8 = b; start8 = 1'b1;
        e.diff   = a - b;
        e.borrow = (a < b);
        e.cyc    = cyc + N8 + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b);
        exp_t e;
        a1 = a; b1 = b; start1 = 1'b1;
        e.diff   = {7'd0, a ^ b};
        e.borrow = (a < b);
        e.cyc    = cyc + N1 + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Counts busy cycles up to and including the done cycle; returns on the
    // falling edge of the done cycle. intr pokes an extra request mid-RUN.
    task automatic wait_done8(input bit intr);
        int busy_cnt = 0;
        int guard    = 0;
        bit seen     = 1'b0;
        while (!seen && guard < 64) begin
            if (busy8 === 1'b1) busy_cnt++;
            if (done8 === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (intr && guard == 2) begin
                    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
                end else if (intr && guard == 3) begin
                    start8 = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
        end
        check("done8_seen", seen, 1);
        if (seen) check("busy_cycles8", busy_cnt, N8 + 1);
        else q8.delete();
    endtask

    task automatic wait_done1();
        int busy_cnt = 0;
        int guard    = 0;
        bit seen     = 1'b0;
        while (!seen && guard < 16) begin
            if (busy1 === 1'b1) busy_cnt++;
            if (done1 === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                guard++;
            end
        end
        check("done1_seen", seen, 1);
        if (seen) check("busy_cycles1", busy_cnt, N1 + 1);
        else q1.delete();
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset values, then idle with start low.
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", diff8, 8'h00);
        check("rst_borrow8", borrow8, 0);
        check("rst_diff1", diff1, 0);
        repeat (3) @(negedge clk);
        check("idle_busy8", busy8, 0);
        check("idle_done8", done8, 0);
        check("idle_busy1", busy1, 0);

        // Basic and boundary operand pairs.
        issue8(8'h5A, 8'h3C); wait_done8(1'b0); @(negedge clk);
        issue8(8'h00, 8'h01); wait_done8(1'b0); @(negedge clk);
        issue8(8'hFF, 8'hFF); wait_done8(1'b0); @(negedge clk);
        issue8(8'h80, 8'h7F); wait_done8(1'b0); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            wait_done8(1'b0);
            @(negedge clk);
        end

        // Request during RUN ignored; request held through DONE taken one cycle later.
        issue8(8'h10, 8'h01);
        wait_done8(1'b1);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        check("idle_after_done8", busy8, 0);
        issue8(8'hAA, 8'h55);
        wait_done8(1'b0);
        @(negedge clk);

        // Reset in RUN cycle 4 aborts with no done pulse.
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_abort", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy8", busy8, 0);
        check("abort_done8", done8, 0);
        check("abort_diff8", diff8, 8'h00);
        check("abort_borrow8", borrow8, 0);
        repeat (12) @(negedge clk);
        check("abort_still_idle8", busy8, 0);
        issue8(8'h03, 8'h05); wait_done8(1'b0); @(negedge clk);

        // Single-bit instance.
        issue1(1'b0, 1'b1); wait_done1(); @(negedge clk);
        issue1(1'b1, 1'b1); wait_done1(); @(negedge clk);
        issue1(1'b1, 1'b0); wait_done1(); @(negedge clk);

        repeat (3) @(negedge clk);
        check("sb_empty8", q8.size(), 0);
        check("sb_empty1", q1.size(), 0);
        check("hold_diff8", diff8, 8'hFE);
        check("hold_borrow8", borrow8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
